// File: rtl/reg_file_2w2r.sv
// Parametrised 2-write / 2-read register file with a per-entry pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write/reserve results to the read ports.
module reg_file_2w2r #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_wa_en,
  input  logic [ADDR_W-1:0] in_wa_add,
  input  logic [DATA_W-1:0] in_wa_data,
  input  logic              in_wb_en,
  input  logic [ADDR_W-1:0] in_wb_add,
  input  logic [DATA_W-1:0] in_wb_data,
  input  logic              in_rsv_en,
  input  logic [ADDR_W-1:0] in_rsv_add,
  input  logic              in_r_en,
  input  logic [ADDR_W-1:0] in_r_add1,
  input  logic [ADDR_W-1:0] in_r_add2,
  output logic [DATA_W-1:0] o_r_data1,
  output logic [DATA_W-1:0] o_r_data2,
  output logic              o_r_pend1,
  output logic              o_r_pend2,
  output logic              o_wr_conflict
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic w_wa_ok;
  logic w_wb_ok;
  logic w_rsv_ok;
  logic w_conflict;

  // Entry 0 is never written when hardwired, so it keeps its reset value of zero.
  assign w_wa_ok    = in_wa_en  && !((ZERO_REG != 0) && (in_wa_add  == '0));
  assign w_wb_ok    = in_wb_en  && !((ZERO_REG != 0) && (in_wb_add  == '0));
  assign w_rsv_ok   = in_rsv_en && !((ZERO_REG != 0) && (in_rsv_add == '0));
  assign w_conflict = w_wa_ok && w_wb_ok && (in_wa_add == in_wb_add);

  function automatic logic [DATA_W-1:0] f_rd_data(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (w_wa_ok && (in_wa_add == a)) return in_wa_data;
    if (w_wb_ok && (in_wb_add == a)) return in_wb_data;
`endif
    return r_mem[a];
  endfunction

  function automatic logic f_rd_pend(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (w_rsv_ok && (in_rsv_add == a)) return 1'b1;
    if ((w_wa_ok && (in_wa_add == a)) || (w_wb_ok && (in_wb_add == a))) return 1'b0;
`endif
    return r_pend[a];
  endfunction

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_pd1;
  logic              w_pd2;

  always_comb begin
    w_rd1 = f_rd_data(in_r_add1);
    w_rd2 = f_rd_data(in_r_add2);
    w_pd1 = f_rd_pend(in_r_add1);
    w_pd2 = f_rd_pend(in_r_add2);
  end

  // Port A is applied after port B and reserve after both, giving A-over-B and reserve-over-clear.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
    end else begin
      if (w_wb_ok) begin
        r_mem[in_wb_add]  <= in_wb_data;
        r_pend[in_wb_add] <= 1'b0;
      end
      if (w_wa_ok) begin
        r_mem[in_wa_add]  <= in_wa_data;
        r_pend[in_wa_add] <= 1'b0;
      end
      if (w_rsv_ok) r_pend[in_rsv_add] <= 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      o_r_data1     <= '0;
      o_r_data2     <= '0;
      o_r_pend1     <= 1'b0;
      o_r_pend2     <= 1'b0;
      o_wr_conflict <= 1'b0;
    end else begin
      o_wr_conflict <= w_conflict;
      if (in_r_en) begin
        o_r_data1 <= w_rd1;
        o_r_data2 <= w_rd2;
        o_r_pend1 <= w_pd1;
        o_r_pend2 <= w_pd2;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed bench for reg_file_2w2r: one instance with ZERO_REG=0 and one with ZERO_REG=1
// share the same stimulus; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_reg_file_2w2r;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        in_wa_en, in_wb_en, in_rsv_en, in_r_en;
  logic [3:0]  in_wa_add, in_wb_add, in_rsv_add, in_r_add1, in_r_add2;
  logic [15:0] in_wa_data, in_wb_data;

  logic [15:0] d1, d2, z_d1, z_d2;
  logic        p1, p2, cf, z_p1, z_p2, z_cf;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 in_clk = ~in_clk;

  reg_file_2w2r #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u_dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_wa_en(in_wa_en), .in_wa_add(in_wa_add), .in_wa_data(in_wa_data),
    .in_wb_en(in_wb_en), .in_wb_add(in_wb_add), .in_wb_data(in_wb_data),
    .in_rsv_en(in_rsv_en), .in_rsv_add(in_rsv_add),
    .in_r_en(in_r_en), .in_r_add1(in_r_add1), .in_r_add2(in_r_add2),
    .o_r_data1(d1), .o_r_data2(d2), .o_r_pend1(p1), .o_r_pend2(p2),
    .o_wr_conflict(cf)
  );

  reg_file_2w2r #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u_dut_z (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_wa_en(in_wa_en), .in_wa_add(in_wa_add), .in_wa_data(in_wa_data),
    .in_wb_en(in_wb_en), .in_wb_add(in_wb_add), .in_wb_data(in_wb_data),
    .in_rsv_en(in_rsv_en), .in_rsv_add(in_rsv_add),
    .in_r_en(in_r_en), .in_r_add1(in_r_add1), .in_r_add2(in_r_add2),
    .o_r_data1(z_d1), .o_r_data2(z_d2), .o_r_pend1(z_p1), .o_r_pend2(z_p2),
    .o_wr_conflict(z_cf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle();
    in_wa_en = 0; in_wb_en = 0; in_rsv_en = 0; in_r_en = 0;
  endtask

  task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
    idle();
    in_r_en = 1; in_r_add1 = a1; in_r_add2 = a2;
  endtask

  initial begin
    in_rst_n = 0;
    idle();
    in_wa_add = '0; in_wb_add = '0; in_rsv_add = '0; in_r_add1 = '0; in_r_add2 = '0;
    in_wa_data = '0; in_wb_data = '0;
    repeat (3) tick();
    check_eq("rst_d1", d1, 0);
    check_eq("rst_p1", p1, 0);
    check_eq("rst_cf", cf, 0);
    in_rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i));
      tick();
      check_eq($sformatf("def_d1_%0d", i), d1, 0);
      check_eq($sformatf("def_d2_%0d", i), d2, 0);
      check_eq($sformatf("def_p1_%0d", i), p1, 0);
      check_eq($sformatf("def_p2_%0d", i), p2, 0);
      check_eq($sformatf("def_cf_%0d", i), cf, 0);
    end

    idle();
    in_wa_en = 1; in_wa_add = 3; in_wa_data = 16'hBEEF;
    in_wb_en = 1; in_wb_add = 7; in_wb_data = 16'h1234;
    tick();
    check_eq("w37_cf", cf, 0);
    rd(3, 7);
    tick();
    check_eq("rd3", d1, 16'hBEEF);
    check_eq("rd7", d2, 16'h1234);

    idle();
    in_wa_en = 1; in_wa_add = 5; in_wa_data = 16'hAAAA;
    in_wb_en = 1; in_wb_add = 5; in_wb_data = 16'h5555;
    tick();
    check_eq("conf5_cf", cf, 1);
    rd(5, 5);
    tick();
    check_eq("conf5_d1", d1, 16'hAAAA);
    check_eq("conf5_d2", d2, 16'hAAAA);
    check_eq("conf5_cf_clr", cf, 0);

    idle();
    in_rsv_en = 1; in_rsv_add = 9;
    tick();
    rd(9, 3);
    tick();
    check_eq("rsv9_p1", p1, 1);
    check_eq("rsv9_p2", p2, 0);
    idle();
    in_rsv_en = 1; in_rsv_add = 9;
    in_wa_en = 1; in_wa_add = 9; in_wa_data = 16'h0042;
    tick();
    rd(9, 9);
    tick();
    check_eq("rsvw9_p1", p1, 1);
    check_eq("rsvw9_d1", d1, 16'h0042);
    idle();
    in_wb_en = 1; in_wb_add = 9; in_wb_data = 16'h0043;
    tick();
    rd(9, 9);
    tick();
    check_eq("w9_p1", p1, 0);
    check_eq("w9_d2", d2, 16'h0043);

    rd(2, 2);
    in_wa_en = 1; in_wa_add = 2; in_wa_data = 16'hCAFE;
    tick();
    check_eq("byp2_d1", d1, BYP ? 16'hCAFE : 16'h0000);
    rd(2, 6);
    in_rsv_en = 1; in_rsv_add = 6;
    tick();
    check_eq("after2_d1", d1, 16'hCAFE);
    check_eq("byp6_p2", p2, BYP ? 1 : 0);
    rd(6, 6);
    tick();
    check_eq("rsv6_p1", p1, 1);

    idle();
    in_wa_en = 1; in_wa_add = 0; in_wa_data = 16'hFFFF;
    tick();
    idle();
    in_rsv_en = 1; in_rsv_add = 0;
    tick();
    rd(0, 0);
    tick();
    check_eq("z0_d1", z_d1, 0);
    check_eq("z0_p1", z_p1, 0);
    check_eq("nz0_d1", d1, 16'hFFFF);
    check_eq("nz0_p2", p2, 1);
    idle();
    in_wa_en = 1; in_wa_add = 0; in_wa_data = 16'h1111;
    in_wb_en = 1; in_wb_add = 0; in_wb_data = 16'h2222;
    tick();
    check_eq("z0_cf", z_cf, 0);
    check_eq("nz0_cf", cf, 1);

    rd(3, 3);
    tick();
    check_eq("pre_rst_d1", d1, 16'hBEEF);
    idle();
    in_wa_en = 1; in_wa_add = 4; in_wa_data = 16'h4444;
    #2 in_rst_n = 0;
    #1;
    check_eq("async_rst_d1", d1, 0);
    check_eq("async_rst_cf", cf, 0);
    tick();
    idle();
    in_rst_n = 1;
    rd(4, 3);
    tick();
    check_eq("rst4_d1", d1, 0);
    check_eq("rst3_d2", d2, 0);
    rd(6, 9);
    tick();
    check_eq("rst6_p1", p1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_2w2r.md
# reg_file_2w2r

Parametrised multi-port register file that succeeds the fixed 16x16 register file: configurable width and depth, two write ports with fixed priority, two registered read ports, and a per-register pending scoreboard for in-flight producers. It sits between the decode stage, which issues read addresses and reservations, and the writeback stage, which drives both write ports. Optional write-to-read forwarding is compiled in by macro.

## Interface
- DATA_W, 16, data width in bits (>=1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 0, 1 = entry 0 is hardwired zero (writes and reservations ignored)

- in_clk  input  1  clock, all state updates on rising edge
- in_rst_n  input  1  asynchronous, active-low reset
- in_wa_en  input  1  write port A enable
- in_wa_add  input  ADDR_W  write port A address
- in_wa_data  input  DATA_W  write port A data
- in_wb_en  input  1  write port B enable
- in_wb_add  input  ADDR_W  write port B address
- in_wb_data  input  DATA_W  write port B data
- in_rsv_en  input  1  reserve enable: set pending bit of in_rsv_add
- in_rsv_add  input  ADDR_W  address to reserve
- in_r_en  input  1  read enable for both read ports
- in_r_add1  input  ADDR_W  read port 1 address
- in_r_add2  input  ADDR_W  read port 2 address
- o_r_data1  output  DATA_W  registered read data, port 1
- o_r_data2  output  DATA_W  registered read data, port 2
- o_r_pend1  output  1  registered pending flag of in_r_add1
- o_r_pend2  output  1  registered pending flag of in_r_add2
- o_wr_conflict  output  1  registered: both write ports hit same address last cycle

## Operation
- Storage: DEPTH x DATA_W array plus DEPTH pending bits.
- Writes: each enabled port writes its data at the edge. Both enabled, same address: port A data stored, port B dropped, o_wr_conflict = 1 for one cycle; otherwise o_wr_conflict = 0.
- Pending: any write (A or B) to an address clears its pending bit. in_rsv_en sets it. Reserve and write to the same address in one cycle: reserve wins, bit ends 1.
- ZERO_REG = 1: entry 0 always reads 0 with pending 0; writes, reservations and conflict flagging for address 0 ignored.
- Reads: with in_r_en = 1, data and pending of both addresses captured into output registers at the edge; with in_r_en = 0 outputs hold. Read ports are independent; same address on both returns identical values.
- Reset (in_rst_n low, asynchronous): all entries 0, all pending bits 0, o_r_data1/2 = 0, o_r_pend1/2 = 0, o_wr_conflict = 0. Reset mid-operation discards any write or reservation in that cycle; first operation accepted at the first rising edge after in_rst_n deasserts.

## Timing
- Write latency: data visible in the array after the edge that samples the write.
- Read latency: 1 cycle; address presented in cycle N, data valid on outputs after edge N, held until next enabled read.
- Same-cycle write and read to same address: behaviour set by the macro below; pending flag follows the same rule as data.
- No handshake stalls; every port accepts every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: read in cycle N returns post-update state of edge N: write data forwarded (port A over port B), pending bit reflects that cycle's write/reserve resolution.
- Not defined: read in cycle N returns pre-update state (old data, old pending bit); the write is visible to reads from cycle N+1.

## Test plan
- Reset then read all 16 addresses (defaults) -> every o_r_data = 0x0000, o_r_pend = 0, o_wr_conflict = 0.
- Write A addr 3 = 0xBEEF, B addr 7 = 0x1234; next cycle read 3 and 7 -> 0xBEEF / 0x1234 one cycle later.
- Both ports write addr 5 (A = 0xAAAA, B = 0x5555) -> o_wr_conflict = 1 next cycle; read 5 -> 0xAAAA.
- Reserve addr 9, read 9 -> pend 1; reserve + write 9 = 0x0042 same cycle -> pend stays 1; write 9 alone -> pend 0.
- Write addr 2 = 0xCAFE with same-cycle read of 2 (old 0x0000) -> 0xCAFE with REGFILE_BYPASS_EN, 0x0000 without.
- ZERO_REG = 1: write 0xFFFF to addr 0, reserve addr 0 -> reads 0x0000, pend 0; assert in_rst_n low mid-write to addr 4 -> addr 4 reads 0.
